axi_lite_initiator: RTL and testbench
=====================================

# axi_lite_initiator

Single-clock AXI4-Lite initiator that turns one-at-a-time read/write commands from PL logic into AXI4-Lite transactions on a 32-bit data / 8-bit address bus. It is the initiator counterpart of our AXI-lite-to-local-bus slave bridge. It lets PL-side sequencers and benches exercise the bridge's register space without the PS. It issues one outstanding transaction at a time, applies a watchdog to every transaction, and returns read data and response codes on a simple valid/ready response port.

## Interface
- TIMEOUT, 1023: cycles a transaction may wait for any AXI handshake before it is declared hung; 1..65535.
- clk  in  1  single clock for all logic.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  8  byte address; driven unmodified on awaddr/araddr.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_wr  out  1  response belongs to a write.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP, or 2'b11 on timeout.
- rsp_timeout  out  1  this response is a watchdog expiry.
- hung  out  1  sticky; set when a watchdog expires; cleared only by rst.
- m_awaddr out 8, m_awprot out 3 (const 0), m_awvalid out 1, m_awready in 1
- m_wdata out 32, m_wstrb out 4, m_wvalid out 1, m_wready in 1
- m_bresp in 2, m_bvalid in 1, m_bready out 1
- m_araddr out 8, m_arprot out 3 (const 0), m_arvalid out 1, m_arready in 1
- m_rdata in 32, m_rresp in 2, m_rvalid in 1, m_rready out 1

## Operation
- States: IDLE, WRITE (AW/W outstanding), WRESP, READ (AR outstanding), RDATA, RSP, HALT.
- IDLE: cmd_ready=1. On accept, the block registers addr, wdata, and wstrb, and goes to WRITE if cmd_wr else READ.
- WRITE: awvalid and wvalid rise together on entry. Each drops independently the cycle after its own handshake. The state leaves for WRESP when both handshakes are done; same-cycle AW and W handshakes are legal.
- WRESP: bready=1. On bvalid the block captures bresp, sets rsp_wr=1 and rsp_rdata=0, and moves to RSP.
- READ: arvalid=1 until arready, then RDATA. RDATA: rready=1. On rvalid the block captures rdata/rresp and moves to RSP.
- RSP: rsp_valid=1 and the response fields are held stable until rsp_ready, then IDLE. cmd_ready=0 outside IDLE, so no new command is taken in the same cycle as a response handshake.
- Watchdog: a 16-bit counter clears on every state entry and increments each cycle spent in WRITE, WRESP, READ or RDATA.
- When the counter reaches TIMEOUT, the block:
  - sets hung;
  - moves to RSP with rsp_resp=2'b11, rsp_timeout=1, rsp_rdata=0;
  - then enters HALT instead of IDLE.
- Outstanding AXI valids are not withdrawn on timeout. awvalid/wvalid/arvalid stay asserted until their handshake, which keeps the block AXI-compliant. Ready outputs are 0 in HALT. HALT exits only on rst.
- Valid outputs never depend combinationally on AXI ready inputs. All m_* valid/ready outputs are registered.

## Timing
- Reset values:
  - cmd_ready=0 during rst, 1 the first cycle after;
  - rsp_valid, rsp_wr, rsp_timeout, hung = 0; rsp_rdata = 0; rsp_resp = 0;
  - all m_*valid and m_*ready = 0; m_awaddr, m_araddr, m_wdata = 0; m_wstrb = 0.
- rst mid-transaction forces IDLE next cycle, with all valids low. Stranded slave state is the system's problem; benches reset both sides together.
- Latency with zero-wait slave (ready/valid high in the cycle after the request appears):
  - write: accept at cycle 0, AW/W valid cycle 1, handshake cycle 1, bready cycle 2, bvalid handshake cycle 2, rsp_valid cycle 3;
  - read: rsp_valid at cycle 3 by the same pattern.
- Minimum command-to-command spacing is 4 cycles: accept, address, response, RSP.
- Watchdog fires on the cycle the count equals TIMEOUT. rsp_valid follows one cycle later.

## Test plan
- Write addr 0x04, data 0xDEADBEEF, wstrb 0xF to a zero-wait slave -> one AW and one W handshake with those values; rsp_valid at cycle 3 with rsp_wr=1 and rsp_resp=0.
- Slave asserts wready 5 cycles before awready -> wvalid drops right after its handshake, awvalid holds; exactly one response, no duplicate beats.
- Read 0x08; slave returns rdata 0x12345678 with rresp=2'b10 after 7 wait cycles -> rsp_rdata=0x12345678, rsp_resp=2'b10, rsp_wr=0.
- rsp_ready held low 10 cycles -> response fields stable, cmd_ready=0, cmd_valid ignored; accepted after release.
- TIMEOUT=16, slave never asserts arready -> rsp_timeout=1 and resp=2'b11 after 16 cycles; hung=1; arvalid remains 1; cmd_ready stays 0 until rst.
- rst asserted while in WRESP -> all valids low and cmd_ready=1 the cycle after rst deasserts; a following read completes normally.

Source files
------------

// File: rtl/axi_lite_initiator.sv
// axi_lite_initiator: one-at-a-time AXI4-Lite initiator (8-bit address, 32-bit data)
// with a per-state watchdog. Commands come in on a valid/ready port. Responses
// (read data, BRESP/RRESP or timeout) go out on a second valid/ready port.
`timescale 1ns/1ps
module axi_lite_initiator #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [7:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_wr,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    output logic        hung,

    output logic [7:0]  m_awaddr,
    output logic [2:0]  m_awprot,
    output logic        m_awvalid,
    input  logic        m_awready,

    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,

    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,

    output logic [7:0]  m_araddr,
    output logic [2:0]  m_arprot,
    output logic        m_arvalid,
    input  logic        m_arready,

    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WRESP,
        S_READ,
        S_RDATA,
        S_RSP,
        S_HALT
    } state_t;

    state_t      r_state;
    logic [15:0] r_wdog;

    logic [7:0]  r_awaddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [7:0]  r_araddr;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_arvalid;
    logic        r_bready;
    logic        r_rready;

    logic        r_rsp_valid;
    logic        r_rsp_wr;
    logic [31:0] r_rsp_rdata;
    logic [1:0]  r_rsp_resp;
    logic        r_rsp_timeout;
    logic        r_hung;

    logic        w_wait_state;
    logic [16:0] w_wdog_inc;
    logic        w_wdog_fire;
    logic        w_aw_done;
    logic        w_w_done;
    logic        w_progress;
    logic        w_timeout;

    assign w_wait_state = (r_state == S_WRITE) || (r_state == S_WRESP) ||
                          (r_state == S_READ)  || (r_state == S_RDATA);
    // The counter value after this cycle's increment is what gets compared, so a
    // state that has waited TIMEOUT cycles fires on its TIMEOUT-th cycle.
    assign w_wdog_inc   = {1'b0, r_wdog} + 17'd1;
    assign w_wdog_fire  = w_wait_state && (w_wdog_inc == 17'(TIMEOUT));

    assign w_aw_done = !r_awvalid || m_awready;
    assign w_w_done  = !r_wvalid  || m_wready;

    // Whether the current waiting state completes its handshake this cycle;
    // normal progress wins over a watchdog expiry in the same cycle.
    always_comb begin
        w_progress = 1'b0;
        case (r_state)
            S_WRITE: w_progress = w_aw_done && w_w_done;
            S_WRESP: w_progress = m_bvalid;
            S_READ:  w_progress = m_arready;
            S_RDATA: w_progress = m_rvalid;
            default: w_progress = 1'b0;
        endcase
    end

    assign w_timeout = w_wdog_fire && !w_progress;

    // Transaction FSM, AXI channel registers, watchdog and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_wdog        <= '0;
            r_awaddr      <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_araddr      <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_bready      <= 1'b0;
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_wr      <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= '0;
            r_rsp_timeout <= 1'b0;
            r_hung        <= 1'b0;
        end else begin
            // Valids drop after their own handshake in every state, so a valid
            // left outstanding by a timeout still completes legally.
            if (r_awvalid && m_awready) r_awvalid <= 1'b0;
            if (r_wvalid  && m_wready)  r_wvalid  <= 1'b0;
            if (r_arvalid && m_arready) r_arvalid <= 1'b0;

            if (w_wait_state) r_wdog <= w_wdog_inc[15:0];

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_wdog <= '0;
                        if (cmd_wr) begin
                            r_awaddr  <= cmd_addr;
                            r_wdata   <= cmd_wdata;
                            r_wstrb   <= cmd_wstrb;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WRITE;
                        end else begin
                            r_araddr  <= cmd_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_wdog   <= '0;
                        r_state  <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (m_bvalid) begin
                        r_bready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_wr      <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_resp    <= m_bresp;
                        r_rsp_timeout <= 1'b0;
                        r_wdog        <= '0;
                        r_state       <= S_RSP;
                    end
                end
                S_READ: begin
                    if (m_arready) begin
                        r_rready <= 1'b1;
                        r_wdog   <= '0;
                        r_state  <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (m_rvalid) begin
                        r_rready      <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_wr      <= 1'b0;
                        r_rsp_rdata   <= m_rdata;
                        r_rsp_resp    <= m_rresp;
                        r_rsp_timeout <= 1'b0;
                        r_wdog        <= '0;
                        r_state       <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_wdog      <= '0;
                        r_state     <= r_hung ? S_HALT : S_IDLE;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Watchdog expiry overrides the per-state updates above.
            if (w_timeout) begin
                r_hung        <= 1'b1;
                r_bready      <= 1'b0;
                r_rready      <= 1'b0;
                r_rsp_valid   <= 1'b1;
                r_rsp_wr      <= (r_state == S_WRITE) || (r_state == S_WRESP);
                r_rsp_rdata   <= '0;
                r_rsp_resp    <= 2'b11;
                r_rsp_timeout <= 1'b1;
                r_wdog        <= '0;
                r_state       <= S_RSP;
            end
        end
    end

    assign cmd_ready   = (r_state == S_IDLE) && !rst;

    assign rsp_valid   = r_rsp_valid;
    assign rsp_wr      = r_rsp_wr;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_resp    = r_rsp_resp;
    assign rsp_timeout = r_rsp_timeout;
    assign hung        = r_hung;

    assign m_awaddr    = r_awaddr;
    assign m_awprot    = '0;
    assign m_awvalid   = r_awvalid;
    assign m_wdata     = r_wdata;
    assign m_wstrb     = r_wstrb;
    assign m_wvalid    = r_wvalid;
    assign m_bready    = r_bready;
    assign m_araddr    = r_araddr;
    assign m_arprot    = '0;
    assign m_arvalid   = r_arvalid;
    assign m_rready    = r_rready;

endmodule

// File: tb/tb_axi_lite_initiator.sv
// Directed bench for axi_lite_initiator: the bench plays the AXI slave by hand,
// cycle by cycle, with TIMEOUT=16.
`timescale 1ns/1ps
module tb_axi_lite_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_wr, rsp_timeout, hung;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  m_awaddr, m_araddr;
    logic [2:0]  m_awprot, m_arprot;
    logic        m_awvalid, m_awready, m_wvalid, m_wready;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

    int n_pass  = 0;
    int n_total = 0;
    int aw_cnt  = 0;
    int w_cnt   = 0;
    int ar_cnt  = 0;
    int rsp_cnt = 0;
    int aw0, w0, rsp0;

    axi_lite_initiator #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .hung(hung),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 clk = ~clk;

    // Handshake counters sampled on the active edge.
    always @(posedge clk) begin
        if (!rst) begin
            if (m_awvalid && m_awready) aw_cnt++;
            if (m_wvalid && m_wready)   w_cnt++;
            if (m_arvalid && m_arready) ar_cnt++;
            if (rsp_valid && rsp_ready) rsp_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        rst = 1'b1; cmd_valid = 0; cmd_wr = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 0; m_awready = 0; m_wready = 0; m_bresp = '0; m_bvalid = 0;
        m_arready = 0; m_rdata = '0; m_rresp = '0; m_rvalid = 0;

        // ---- reset values ----
        tick(); tick();
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_valids", 32'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid}), 0);
        check("rst_rsp", 32'({rsp_wr, rsp_timeout, hung, rsp_resp}), 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_wdata", m_wdata, 0);
        check("rst_addr", 32'({m_awaddr, m_araddr, m_wstrb}), 0);
        rst = 1'b0;
        #1;
        check("post_rst_cmd_ready", 32'(cmd_ready), 1);

        // ---- write 0x04 <= DEADBEEF, zero-wait slave ----
        cmd_valid = 1; cmd_wr = 1; cmd_addr = 8'h04; cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
        m_awready = 1; m_wready = 1;
        tick();                                  // cycle 1
        cmd_valid = 0;
        check("w1_awvalid", 32'({m_awvalid, m_wvalid}), 32'b11);
        check("w1_awaddr", 32'(m_awaddr), 32'h04);
        check("w1_wdata", m_wdata, 32'hDEADBEEF);
        check("w1_wstrb", 32'(m_wstrb), 32'hF);
        check("w1_prot", 32'({m_awprot, m_arprot}), 0);
        check("w1_cmd_ready", 32'(cmd_ready), 0);
        tick();                                  // cycle 2
        m_awready = 0; m_wready = 0;
        check("w1_valids_drop", 32'({m_awvalid, m_wvalid}), 0);
        check("w1_bready", 32'(m_bready), 1);
        m_bvalid = 1; m_bresp = 2'b00;
        tick();                                  // cycle 3
        m_bvalid = 0;
        check("w1_rsp_valid", 32'(rsp_valid), 1);
        check("w1_rsp_fields", 32'({rsp_wr, rsp_timeout, rsp_resp}), 32'b1000);
        check("w1_rsp_rdata", rsp_rdata, 0);
        check("w1_bready_drop", 32'(m_bready), 0);
        check("w1_hs_counts", 32'({aw_cnt[3:0], w_cnt[3:0]}), 32'h11);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        check("w1_idle", 32'({rsp_valid, cmd_ready}), 32'b01);

        // ---- write with W accepted 5 cycles before AW ----
        aw0 = aw_cnt; w0 = w_cnt; rsp0 = rsp_cnt;
        cmd_valid = 1; cmd_wr = 1; cmd_addr = 8'h10; cmd_wdata = 32'hA5A50F0F; cmd_wstrb = 4'h3;
        tick();                                  // cycle 1
        cmd_valid = 0;
        m_wready = 1;
        tick();                                  // cycle 2: W done
        m_wready = 0;
        check("w2_w_drop", 32'({m_awvalid, m_wvalid}), 32'b10);
        repeat (4) begin
            check("w2_aw_hold", 32'({m_awvalid, m_wvalid, m_bready}), 32'b100);
            tick();
        end
        m_awready = 1;
        tick();                                  // AW handshake
        m_awready = 0;
        check("w2_bready", 32'({m_awvalid, m_bready}), 32'b01);
        m_bvalid = 1; m_bresp = 2'b01;
        tick();
        m_bvalid = 0;
        check("w2_rsp", 32'({rsp_valid, rsp_wr, rsp_resp}), 32'b1101);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        check("w2_aw_count", 32'(aw_cnt - aw0), 1);
        check("w2_w_count", 32'(w_cnt - w0), 1);
        check("w2_rsp_count", 32'(rsp_cnt - rsp0), 1);
        tick();
        check("w2_no_dup_rsp", 32'(rsp_valid), 0);

        // ---- read 0x08 with 7 wait cycles on R ----
        cmd_valid = 1; cmd_wr = 0; cmd_addr = 8'h08;
        tick();                                  // cycle 1
        cmd_valid = 0;
        check("r1_arvalid", 32'({m_arvalid, m_awvalid}), 32'b10);
        check("r1_araddr", 32'(m_araddr), 32'h08);
        m_arready = 1;
        tick();                                  // cycle 2
        m_arready = 0;
        check("r1_rready", 32'({m_arvalid, m_rready}), 32'b01);
        repeat (7) begin
            check("r1_wait", 32'({m_rready, rsp_valid}), 32'b10);
            tick();
        end
        m_rvalid = 1; m_rdata = 32'h12345678; m_rresp = 2'b10;
        tick();
        m_rvalid = 0; m_rdata = '0; m_rresp = '0;
        check("r1_rsp_valid", 32'({rsp_valid, m_rready}), 32'b10);
        check("r1_rdata", rsp_rdata, 32'h12345678);
        check("r1_resp", 32'({rsp_wr, rsp_timeout, rsp_resp}), 32'b0010);

        // ---- rsp_ready held low 10 cycles with a command pending ----
        cmd_valid = 1; cmd_wr = 1; cmd_addr = 8'h20; cmd_wdata = 32'h0000_0055; cmd_wstrb = 4'h1;
        repeat (10) begin
            check("bp_hold", 32'({rsp_valid, cmd_ready, m_awvalid, rsp_resp}), 32'b10010);
            check("bp_rdata", rsp_rdata, 32'h12345678);
            tick();
        end
        rsp_ready = 1;
        check("bp_no_accept_on_rsp", 32'(cmd_ready), 0);
        tick();
        rsp_ready = 0;
        check("bp_released", 32'({rsp_valid, cmd_ready, m_awvalid}), 32'b010);
        tick();                                  // accept
        cmd_valid = 0;
        check("bp_next_cmd", 32'({m_awvalid, m_wvalid, m_awaddr}), 32'h320);
        m_awready = 1; m_wready = 1;
        tick();
        m_awready = 0; m_wready = 0;
        m_bvalid = 1; m_bresp = 2'b00;
        tick();
        m_bvalid = 0;
        check("bp_next_rsp", 32'({rsp_valid, rsp_wr, rsp_resp}), 32'b1100);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;

        // ---- reset in WRESP, then a normal read ----
        cmd_valid = 1; cmd_wr = 1; cmd_addr = 8'h24; cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
        tick();
        cmd_valid = 0;
        m_awready = 1; m_wready = 1;
        tick();
        m_awready = 0; m_wready = 0;
        check("rw_in_wresp", 32'(m_bready), 1);
        rst = 1;
        tick();
        rst = 0;
        #1;
        check("rw_after_rst", 32'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid}), 0);
        check("rw_cmd_ready", 32'(cmd_ready), 1);
        cmd_valid = 1; cmd_wr = 0; cmd_addr = 8'h0C;
        tick();
        cmd_valid = 0;
        m_arready = 1;
        tick();
        m_arready = 0;
        m_rvalid = 1; m_rdata = 32'hCAFEF00D; m_rresp = 2'b00;
        tick();
        m_rvalid = 0;
        check("rw_read_rsp", 32'({rsp_valid, rsp_wr, rsp_timeout, rsp_resp}), 32'b10000);
        check("rw_read_data", rsp_rdata, 32'hCAFEF00D);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;

        // ---- watchdog: arready never asserted, TIMEOUT=16 ----
        cmd_valid = 1; cmd_wr = 0; cmd_addr = 8'h30;
        tick();                                  // cycle 1 in READ
        cmd_valid = 0;
        repeat (15) begin
            check("to_waiting", 32'({rsp_valid, m_arvalid, hung}), 32'b010);
            tick();
        end
        check("to_cycle16", 32'({rsp_valid, hung}), 0);
        tick();                                  // watchdog fired last edge
        check("to_rsp", 32'({rsp_valid, rsp_timeout, rsp_resp, rsp_wr}), 32'b11110);
        check("to_rdata", rsp_rdata, 0);
        check("to_hung_arvalid", 32'({hung, m_arvalid, m_rready}), 32'b110);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        cmd_valid = 1; cmd_wr = 1;
        repeat (3) begin
            check("halt_stuck", 32'({cmd_ready, rsp_valid, hung, m_arvalid, m_awvalid}), 32'b00110);
            tick();
        end
        cmd_valid = 0;
        m_arready = 1;
        tick();
        m_arready = 0;
        check("halt_ar_drop", 32'({m_arvalid, m_rready, cmd_ready, hung}), 32'b0001);
        rst = 1;
        tick();
        rst = 0;
        #1;
        check("halt_rst_clear", 32'({hung, cmd_ready, rsp_valid}), 32'b010);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
